// File: rtl/mem_data_bridge_if.sv
// Valid/ready memory port for mem_data_bridge: separate read and write request/reply channels.
interface mem_data_bridge_if #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64
);
    logic                    r_request_valid;
    logic                    r_request_ready;
    logic [ADDR_WIDTH-1:0]   raddr;

    logic                    r_reply_valid;
    logic                    r_reply_ready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;

    logic                    w_request_valid;
    logic                    w_request_ready;
    logic [ADDR_WIDTH-1:0]   waddr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wmask;

    logic                    w_reply_valid;
    logic                    w_reply_ready;
    logic [1:0]              bresp;

    modport master (
        output r_request_valid, raddr, r_reply_ready,
        output w_request_valid, waddr, wdata, wmask, w_reply_ready,
        input  r_request_ready, r_reply_valid, rdata, rresp,
        input  w_request_ready, w_reply_valid, bresp
    );

    modport slave (
        input  r_request_valid, raddr, r_reply_ready,
        input  w_request_valid, waddr, wdata, wmask, w_reply_ready,
        output r_request_ready, r_reply_valid, rdata, rresp,
        output w_request_ready, w_reply_valid, bresp
    );
endinterface

// File: rtl/mem_data_bridge.sv
// Bridges a stall-style CPU data port onto a valid/ready memory interface, one access at a time.
module mem_data_bridge #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata,
    input  logic [DATA_WIDTH/8-1:0] cpu_wmask,
    output logic                    cpu_stall,
    output logic                    cpu_done,
    output logic [DATA_WIDTH-1:0]   cpu_rdata,
    output logic                    cpu_err,
    mem_data_bridge_if.master       mem_ift
);

    localparam logic [1:0] RespOkay = 2'b00;

    typedef enum logic [2:0] {
        StIdle,
        StRreq,
        StRresp,
        StWreq,
        StWresp,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] wmask_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    err_q;

    logic latch_en;
    logic r_fire;
    logic w_fire;
    logic rq_valid;
    logic rr_ready;
    logic wq_valid;
    logic wr_ready;

    // Load/store direction is carried by the state itself, so cpu_we is not kept after IDLE.
    always_comb begin
        state_d  = state_q;
        latch_en = 1'b0;
        r_fire   = 1'b0;
        w_fire   = 1'b0;
        rq_valid = 1'b0;
        rr_ready = 1'b0;
        wq_valid = 1'b0;
        wr_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cpu_req) begin
                    latch_en = 1'b1;
                    state_d  = cpu_we ? StWreq : StRreq;
                end
            end
            StRreq: begin
                rq_valid = 1'b1;
                if (mem_ift.r_request_ready) state_d = StRresp;
            end
            StRresp: begin
                rr_ready = 1'b1;
                if (mem_ift.r_reply_valid) begin
                    r_fire  = 1'b1;
                    state_d = StDone;
                end
            end
            StWreq: begin
                wq_valid = 1'b1;
                if (mem_ift.w_request_ready) state_d = StWresp;
            end
            StWresp: begin
                wr_ready = 1'b1;
                if (mem_ift.w_reply_valid) begin
                    w_fire  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch_en) begin
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
                wmask_q <= cpu_wmask;
            end
            if (r_fire) begin
                rdata_q <= mem_ift.rdata;
                err_q   <= (mem_ift.rresp != RespOkay);
            end
            if (w_fire) begin
                err_q <= (mem_ift.bresp != RespOkay);
            end
        end
    end

    // Request fields come only from the latched copy so CPU-side changes cannot leak through.
    assign mem_ift.r_request_valid = rq_valid;
    assign mem_ift.raddr           = addr_q;
    assign mem_ift.r_reply_ready   = rr_ready;
    assign mem_ift.w_request_valid = wq_valid;
    assign mem_ift.waddr           = addr_q;
    assign mem_ift.wdata           = wdata_q;
    assign mem_ift.wmask           = wmask_q;
    assign mem_ift.w_reply_ready   = wr_ready;

    assign cpu_done  = (state_q == StDone);
    assign cpu_err   = cpu_done & err_q;
    assign cpu_rdata = rdata_q;
    assign cpu_stall = cpu_req & ~cpu_done;

endmodule

// File: tb/tb_mem_data_bridge.sv
// Randomized scoreboard bench for mem_data_bridge with a delay/error-programmable memory slave.
module tb_mem_data_bridge;
    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [7:0]    cpu_wmask;
    logic          cpu_stall, cpu_done, cpu_err;
    logic [DW-1:0] cpu_rdata;

    mem_data_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mif ();

    mem_data_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_wmask (cpu_wmask),
        .cpu_stall (cpu_stall),
        .cpu_done  (cpu_done),
        .cpu_rdata (cpu_rdata),
        .cpu_err   (cpu_err),
        .mem_ift   (mif.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic check(input bit ok, input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {logic [63:0] rdata; logic err;} exp_t;
    typedef struct {int req_wait; int rsp_wait; logic [1:0] resp;} plan_t;
    typedef struct {bit is_read; logic [63:0] data; logic [1:0] resp; int delay;} pend_t;

    exp_t  exp_q[$];
    plan_t plan_q[$];
    pend_t pend_q[$];

    logic [63:0] slave_mem [logic [63:0]];
    logic [63:0] ref_mem   [logic [63:0]];
    logic [63:0] ref_last_rdata = '0;
    int          exp_fires = 0;
    int          exp_dones = 0;

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                          input logic [7:0] m);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Memory slave: decides ready/valid on the falling edge for the next rising edge.
    plan_t cur_plan;
    bit    cur_active = 0;
    int    wait_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            pend_q.delete();
            cur_active = 0;
            mif.r_request_ready = 0; mif.w_request_ready = 0;
            mif.r_reply_valid = 0;   mif.w_reply_valid = 0;
            mif.rdata = '0; mif.rresp = OKAY; mif.bresp = OKAY;
        end else begin
            mif.r_reply_valid = 0;
            mif.w_reply_valid = 0;
            if (pend_q.size() > 0) begin
                if (pend_q[0].delay > 0) begin
                    pend_q[0].delay = pend_q[0].delay - 1;
                end else if (pend_q[0].is_read) begin
                    mif.r_reply_valid = 1;
                    mif.rdata = pend_q[0].data;
                    mif.rresp = pend_q[0].resp;
                    if (mif.r_reply_ready) void'(pend_q.pop_front());
                end else begin
                    mif.w_reply_valid = 1;
                    mif.bresp = pend_q[0].resp;
                    if (mif.w_reply_ready) void'(pend_q.pop_front());
                end
            end
            mif.r_request_ready = 0;
            mif.w_request_ready = 0;
            if (mif.r_request_valid || mif.w_request_valid) begin
                if (!cur_active) begin
                    if (plan_q.size() > 0) cur_plan = plan_q.pop_front();
                    else cur_plan = '{0, 0, OKAY};
                    cur_active = 1;
                    wait_cnt = cur_plan.req_wait;
                end
                if (wait_cnt > 0) begin
                    wait_cnt--;
                end else if (mif.r_request_valid) begin
                    mif.r_request_ready = 1;
                    pend_q.push_back('{1, slave_mem.exists(mif.raddr) ? slave_mem[mif.raddr] : 64'h0,
                                       cur_plan.resp, cur_plan.rsp_wait});
                    cur_active = 0;
                end else begin
                    mif.w_request_ready = 1;
                    if (cur_plan.resp == OKAY)
                        slave_mem[mif.waddr] = merge(slave_mem.exists(mif.waddr) ?
                            slave_mem[mif.waddr] : 64'h0, mif.wdata, mif.wmask);
                    pend_q.push_back('{0, 64'h0, cur_plan.resp, cur_plan.rsp_wait});
                    cur_active = 0;
                end
            end
        end
    end

    // Monitor: scoreboard pop on cpu_done plus channel protocol checks.
    int          fires = 0;
    int          done_cnt = 0;
    bit          prev_rstall = 0, prev_wstall = 0;
    logic [63:0] prev_raddr, prev_waddr, prev_wdata;
    logic [7:0]  prev_wmask;
    logic [3:0]  act;
    exp_t        mon_e;

    always @(negedge clk) begin
        #1;
        act = {mif.r_request_valid, mif.r_reply_ready, mif.w_request_valid, mif.w_reply_ready};
        if (act != 4'b0) check($countones(act) == 1, "one_channel", {60'h0, act}, 64'h1);
        if (prev_rstall && !rst)
            check(mif.r_request_valid && mif.raddr == prev_raddr, "raddr_stable", mif.raddr,
                  prev_raddr);
        if (prev_wstall && !rst)
            check(mif.w_request_valid && mif.waddr == prev_waddr && mif.wdata == prev_wdata &&
                  mif.wmask == prev_wmask, "wreq_stable", mif.wdata, prev_wdata);
        prev_rstall = !rst && mif.r_request_valid && !mif.r_request_ready;
        prev_wstall = !rst && mif.w_request_valid && !mif.w_request_ready;
        prev_raddr = mif.raddr;
        prev_waddr = mif.waddr; prev_wdata = mif.wdata; prev_wmask = mif.wmask;
        if (!rst && ((mif.r_request_valid && mif.r_request_ready) ||
                     (mif.w_request_valid && mif.w_request_ready))) fires++;
        if (cpu_done) begin
            done_cnt++;
            check(act == 4'b0, "no_req_in_done", {60'h0, act}, 64'h0);
            if (exp_q.size() == 0) begin
                check(0, "unexpected_done", 64'h1, 64'h0);
            end else begin
                mon_e = exp_q.pop_front();
                check(cpu_rdata == mon_e.rdata, "sb_rdata", cpu_rdata, mon_e.rdata);
                check(cpu_err == mon_e.err, "sb_err", {63'h0, cpu_err}, {63'h0, mon_e.err});
            end
        end
    end

    task automatic do_reset();
        rst = 1; cpu_req = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        exp_q.delete(); plan_q.delete();
        ref_last_rdata = '0;
    endtask

    // Issues one access from a falling edge and waits for its completion pulse.
    task automatic access(input bit we, input logic [63:0] a, input logic [63:0] wd,
                          input logic [7:0] m, input int rqw, input int rsw,
                          input logic [1:0] resp, input bit keep_req);
        exp_t e;
        int   lat, cyc;
        bit   b2b, stall_ok;
        b2b = (cpu_done === 1'b1);
        plan_q.push_back('{rqw, rsw, resp});
        e.err = (resp != OKAY);
        if (!we) begin
            e.rdata = ref_mem.exists(a) ? ref_mem[a] : 64'h0;
            ref_last_rdata = e.rdata;
        end else begin
            if (resp == OKAY) ref_mem[a] = merge(ref_mem.exists(a) ? ref_mem[a] : 64'h0, wd, m);
            e.rdata = ref_last_rdata;
        end
        exp_q.push_back(e);
        exp_fires++; exp_dones++;
        cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_wmask = m;
        lat = 3 + rqw + rsw + (b2b ? 1 : 0);
        cyc = 0; stall_ok = 1;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1 + int'(b2b)) begin
                cpu_we = 1'($urandom); cpu_addr = {$urandom, $urandom};
                cpu_wdata = {$urandom, $urandom}; cpu_wmask = 8'($urandom);
            end
            if (cpu_done) break;
            if (!cpu_stall) stall_ok = 0;
            if (cyc > 200) break;
        end
        check(cyc == lat, "latency", 64'(cyc), 64'(lat));
        if (cyc > 200) begin
            do_reset();
        end else begin
            check(stall_ok, "stall_while_busy", 64'(stall_ok), 64'h1);
            check(cpu_stall == 1'b0, "stall_at_done", {63'h0, cpu_stall}, 64'h0);
        end
        if (!keep_req) cpu_req = 0;
    endtask

    initial begin
        rst = 1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_wmask = '0;
        repeat (3) @(negedge clk);
        check({mif.r_request_valid, mif.r_reply_ready, mif.w_request_valid, mif.w_reply_ready}
              == 4'b0, "reset_valids", 64'h0, 64'h0);
        check(cpu_done == 0, "reset_done", {63'h0, cpu_done}, 64'h0);
        check(cpu_err == 0, "reset_err", {63'h0, cpu_err}, 64'h0);
        check(cpu_rdata == 64'h0, "reset_rdata", cpu_rdata, 64'h0);
        cpu_req = 1; #1;
        check(cpu_stall == 1, "stall_in_reset", {63'h0, cpu_stall}, 64'h1);
        cpu_req = 0;
        @(negedge clk);
        rst = 0;
        slave_mem[64'h10] = 64'h1122334455667788; ref_mem[64'h10] = 64'h1122334455667788;
        slave_mem[64'h18] = 64'hFFFFFFFFFFFFFFFF; ref_mem[64'h18] = 64'hFFFFFFFFFFFFFFFF;
        @(negedge clk);

        access(0, 64'h10, 64'h0, 8'h00, 0, 0, OKAY, 0);
        check(cpu_rdata == 64'h1122334455667788, "load_word", cpu_rdata, 64'h1122334455667788);
        check(cpu_err == 0, "load_err", {63'h0, cpu_err}, 64'h0);
        @(negedge clk);

        access(1, 64'h18, 64'h00000000AABBCCDD, 8'h0F, 0, 0, OKAY, 0);
        access(0, 64'h18, 64'h0, 8'h00, 0, 0, OKAY, 0);
        check(cpu_rdata == 64'hFFFFFFFFAABBCCDD, "store_merge", cpu_rdata, 64'hFFFFFFFFAABBCCDD);
        @(negedge clk);

        access(0, 64'h10, 64'h0, 8'h00, 3, 2, OKAY, 0);
        @(negedge clk);

        access(1, 64'h20, 64'h1234, 8'hFF, 0, 1, SLVERR, 0);
        check(cpu_err == 1, "store_slverr", {63'h0, cpu_err}, 64'h1);
        @(negedge clk);
        check(cpu_err == 0, "err_one_cycle", {63'h0, cpu_err}, 64'h0);
        access(0, 64'h10, 64'h0, 8'h00, 0, 0, OKAY, 0);
        check(cpu_err == 0, "okay_after_err", {63'h0, cpu_err}, 64'h0);
        @(negedge clk);

        // Reset while waiting for the read reply; the access must vanish silently.
        plan_q.push_back('{0, 6, OKAY});
        exp_fires++;
        cpu_req = 1; cpu_we = 0; cpu_addr = 64'h10;
        repeat (3) @(negedge clk);
        check(mif.r_reply_ready == 1, "in_rresp", {63'h0, mif.r_reply_ready}, 64'h1);
        #1 rst = 1; cpu_req = 0;
        @(negedge clk);
        check({mif.r_request_valid, mif.r_reply_ready, mif.w_request_valid, mif.w_reply_ready}
              == 4'b0, "midop_valids", 64'h0, 64'h0);
        check(cpu_done == 0, "midop_no_done", {63'h0, cpu_done}, 64'h0);
        check(cpu_rdata == 64'h0, "midop_rdata", cpu_rdata, 64'h0);
        #1 rst = 0;
        plan_q.delete(); exp_q.delete(); ref_last_rdata = '0;
        @(negedge clk);
        check(cpu_done == 0, "midop_no_done2", {63'h0, cpu_done}, 64'h0);
        access(0, 64'h18, 64'h0, 8'h00, 0, 0, OKAY, 0);
        check(cpu_rdata == 64'hFFFFFFFFAABBCCDD, "load_after_reset", cpu_rdata,
              64'hFFFFFFFFAABBCCDD);

        for (int i = 0; i < 40; i++) begin
            bit keep;
            keep = 1'($urandom);
            access(1'($urandom), 64'h100 + 64'(8 * $urandom_range(0, 7)), {$urandom, $urandom},
                   8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                   ($urandom_range(0, 9) == 0) ? SLVERR : OKAY, keep);
            if (!keep) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        cpu_req = 0;
        repeat (4) @(negedge clk);
        check(fires == exp_fires, "request_count", 64'(fires), 64'(exp_fires));
        check(done_cnt == exp_dones, "done_count", 64'(done_cnt), 64'(exp_dones));
        check(exp_q.size() == 0, "sb_drained", 64'(exp_q.size()), 64'h0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
